// File: rtl/fifo_line_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_line_rd_stream
// Purpose  : Pulls pixels from a fixed-latency FIFO read port into a ready/valid
//            stream with per-line pixel index, end-of-line flag and line pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_line_rd_stream #(
  parameter int c_DATA_WIDTH = 1,
  parameter int c_RD_LATENCY = 1,
  parameter int c_LINE_LEN   = 1920,
  parameter int c_CNT_WIDTH  = 12
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    enable,
  output logic                    fifo_rd_en,
  input  logic                    fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_eol,
  output logic                    line_done,
  output logic [c_CNT_WIDTH-1:0]  pix_cnt
);

  localparam int                     c_DEPTH    = c_RD_LATENCY + 1;
  localparam int                     c_PTR_W    = 2;
  localparam logic [2:0]             c_DEPTH_W  = 3'(c_DEPTH);
  localparam logic [c_PTR_W-1:0]     c_PTR_LAST = c_PTR_W'(c_DEPTH - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_LAST_PIX = c_CNT_WIDTH'(c_LINE_LEN - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_PIX_ONE  = c_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_DATA_WIDTH-1:0] r_buf [2**c_PTR_W];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [2:0]              r_occ;
  logic [2:0]              r_infl;
  logic [c_RD_LATENCY-1:0] r_ret_pipe;
  logic [c_CNT_WIDTH-1:0]  r_pix_cnt;
  logic                    r_line_done;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_rd_en;
  logic [2:0]              w_occ_after_pop;
  logic [2:0]              w_occ_nxt;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Return data lands exactly c_RD_LATENCY cycles after the strobe.
  assign w_push          = r_ret_pipe[c_RD_LATENCY-1];
  assign w_pop           = m_valid && m_ready;
  assign w_occ_after_pop = r_occ - {2'b00, w_pop};
  assign w_occ_nxt       = w_occ_after_pop + {2'b00, w_push};

  // Credit rule: buffered + in-flight words can never exceed the buffer depth.
  assign w_rd_en = !rd_rst && enable && !fifo_rd_empty && (r_state == S_RUN) &&
                   ((w_occ_after_pop + r_infl) < c_DEPTH_W);

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = !rd_rst && (r_occ != 3'd0);
  assign m_data     = rd_rst ? '0 : r_buf[r_rd_ptr];
  assign m_eol      = m_valid && (r_pix_cnt == c_LAST_PIX);
  assign line_done  = !rd_rst && r_line_done;
  assign pix_cnt    = r_pix_cnt;

  generate
    if (c_RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
          r_ret_pipe <= '0;
        end else begin
          r_ret_pipe <= w_rd_en;
        end
      end
    end else begin : g_lat2
      always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
          r_ret_pipe <= '0;
        end else begin
          r_ret_pipe <= {r_ret_pipe[0], w_rd_en};
        end
      end
    end
  endgenerate

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      for (int i = 0; i < 2**c_PTR_W; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[r_wr_ptr] <= fifo_rd_data;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_occ       <= '0;
      r_infl      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pix_cnt   <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_infl      <= r_infl + {2'b00, w_rd_en} - {2'b00, w_push};
      r_line_done <= w_pop && m_eol;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr  <= ptr_inc(r_rd_ptr);
        r_pix_cnt <= (r_pix_cnt == c_LAST_PIX) ? '0 : r_pix_cnt + c_PIX_ONE;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enable) begin
          w_state_nxt = S_RUN;
        end else if ((r_infl == 3'd0) && (r_occ == 3'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      assert (!(w_push && (w_occ_after_pop >= c_DEPTH_W)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_line_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_line_rd_stream
// Purpose  : Scoreboard bench for fifo_line_rd_stream at read latency 2 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_line_rd_stream;

  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    en, empty, ready;
  logic [DW-1:0] rd_data [2];
  wire  [1:0]    rd_en, valid, eol, ldone;
  wire  [DW-1:0] m_data [2];
  wire  [CW-1:0] pix [2];

  always #5 clk = ~clk;

  fifo_line_rd_stream #(
    .c_DATA_WIDTH(DW), .c_RD_LATENCY(2), .c_LINE_LEN(4), .c_CNT_WIDTH(CW)
  ) dut_l2 (
    .rd_clk(clk), .rd_rst(rst), .enable(en[0]), .fifo_rd_en(rd_en[0]),
    .fifo_rd_empty(empty[0]), .fifo_rd_data(rd_data[0]), .m_valid(valid[0]),
    .m_ready(ready[0]), .m_data(m_data[0]), .m_eol(eol[0]), .line_done(ldone[0]),
    .pix_cnt(pix[0])
  );

  fifo_line_rd_stream #(
    .c_DATA_WIDTH(DW), .c_RD_LATENCY(1), .c_LINE_LEN(5), .c_CNT_WIDTH(CW)
  ) dut_l1 (
    .rd_clk(clk), .rd_rst(rst), .enable(en[1]), .fifo_rd_en(rd_en[1]),
    .fifo_rd_empty(empty[1]), .fifo_rd_data(rd_data[1]), .m_valid(valid[1]),
    .m_ready(ready[1]), .m_data(m_data[1]), .m_eol(eol[1]), .line_done(ldone[1]),
    .pix_cnt(pix[1])
  );

  // FIFO source model, return pipeline and scoreboard state per instance
  int            avail [2];
  logic [DW-1:0] next_w [2];
  logic          ret_v [2][3];
  logic [DW-1:0] ret_d [2][3];
  int            occ_m [2], exp_pix [2], beats [2], rd_cnt [2], ld_cnt [2], eol_cnt [2];
  logic          exp_ld [2], force_empty [2], rnd_mode [2];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            n_tests, n_fail;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int len_of(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic int infl_m(input int i);
    return int'(ret_v[i][0]) + int'(ret_v[i][1]) + int'(ret_v[i][2]);
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qpush(input int i, input logic [DW-1:0] d);
    if (i == 0) exp_q0.push_back(d);
    else        exp_q1.push_back(d);
  endtask

  task automatic qpop(input int i, output logic [DW-1:0] d);
    if (i == 0) d = exp_q0.pop_front();
    else        d = exp_q1.pop_front();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) empty[i] = force_empty[i] || (avail[i] == 0);
  endtask

  // One clock: sample and score at negedge, then advance models after posedge.
  task automatic tick();
    logic [1:0]    xfer;
    logic [1:0]    ld_nxt;
    logic [DW-1:0] d;
    @(negedge clk);
    xfer   = valid & ready;
    ld_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        check($sformatf("valid%0d", i), 32'(valid[i]), 32'(occ_m[i] != 0));
        check($sformatf("line_done%0d", i), 32'(ldone[i]), 32'(exp_ld[i]));
        check($sformatf("pix_cnt%0d", i), 32'(pix[i]), 32'(exp_pix[i]));
        check($sformatf("rd_en_vs_empty%0d", i), 32'(rd_en[i] & empty[i]), 32'(0));
        if (ldone[i]) ld_cnt[i]++;
        if (xfer[i]) begin
          beats[i]++;
          check($sformatf("eol%0d", i), 32'(eol[i]), 32'(exp_pix[i] == len_of(i) - 1));
          if (eol[i]) eol_cnt[i]++;
          check($sformatf("beat_has_data%0d", i), 32'(qsize(i) != 0), 32'(1));
          if (qsize(i) != 0) begin
            qpop(i, d);
            check($sformatf("data%0d", i), 32'(m_data[i]), 32'(d));
          end
          ld_nxt[i]  = (exp_pix[i] == len_of(i) - 1);
          exp_pix[i] = ld_nxt[i] ? 0 : exp_pix[i] + 1;
          occ_m[i]--;
        end
        if (rd_en[i] && !empty[i]) begin
          rd_cnt[i]++;
          avail[i]--;
          ret_v[i][lat_of(i)] = 1'b1;
          ret_d[i][lat_of(i)] = next_w[i];
          qpush(i, next_w[i]);
          next_w[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (i == 0) exp_q0.delete();
        else        exp_q1.delete();
        occ_m[i]   = 0;
        exp_pix[i] = 0;
        exp_ld[i]  = 1'b0;
      end else begin
        if (ret_v[i][0]) occ_m[i]++;
        check($sformatf("no_overflow%0d", i), 32'(occ_m[i] <= lat_of(i) + 1), 32'(1));
        exp_ld[i] = ld_nxt[i];
      end
      ret_v[i][0] = ret_v[i][1];
      ret_v[i][1] = ret_v[i][2];
      ret_v[i][2] = 1'b0;
      ret_d[i][0] = ret_d[i][1];
      ret_d[i][1] = ret_d[i][2];
      ret_d[i][2] = DW'($urandom);
      if (rst) begin
        for (int k = 0; k < 3; k++) ret_v[i][k] = 1'b0;
      end
      rd_data[i] = ret_d[i][0];
      if (rnd_mode[i]) begin
        ready[i]       = ($urandom_range(0, 3) != 0);
        force_empty[i] = ($urandom_range(0, 3) == 0);
        en[i]          = ($urandom_range(0, 31) != 0);
        if (avail[i] < 3) avail[i] += $urandom_range(1, 6);
      end
    end
    apply();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            b0, rc, e0, l0, k;
    logic [DW-1:0] hold;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    en      = '0;
    ready   = '0;
    for (int i = 0; i < 2; i++) begin
      avail[i] = 0; next_w[i] = (i == 0) ? 8'h10 : 8'h80;
      occ_m[i] = 0; exp_pix[i] = 0; beats[i] = 0; rd_cnt[i] = 0;
      ld_cnt[i] = 0; eol_cnt[i] = 0; exp_ld[i] = 1'b0;
      force_empty[i] = 1'b0; rnd_mode[i] = 1'b0; rd_data[i] = '0;
      for (int j = 0; j < 3; j++) begin
        ret_v[i][j] = 1'b0;
        ret_d[i][j] = '0;
      end
    end
    apply();
    tick();
    tick();
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rd_en%0d", i), 32'(rd_en[i]), 32'(0));
      check($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'(0));
      check($sformatf("rst_eol%0d", i), 32'(eol[i]), 32'(0));
      check($sformatf("rst_line_done%0d", i), 32'(ldone[i]), 32'(0));
      check($sformatf("rst_pix%0d", i), 32'(pix[i]), 32'(0));
      check($sformatf("rst_data%0d", i), 32'(m_data[i]), 32'(0));
    end
    rst = 1'b0;

    // Stream 10 words, sustained rate, then a 5-cycle stall
    en[0] = 1'b1; ready[0] = 1'b1; avail[0] = 10; apply();
    for (k = 0; k < 20 && occ_m[0] == 0; k++) tick();
    check("first_beat_seen", 32'(occ_m[0] != 0), 32'(1));
    b0 = beats[0];
    repeat (5) tick();
    check("throughput", 32'(beats[0] - b0), 32'(5));
    ready[0] = 1'b0;
    #2;
    hold = m_data[0];
    repeat (5) begin
      tick();
      #2;
      check("stall_valid", 32'(valid[0]), 32'(1));
      check("stall_data", 32'(m_data[0]), 32'(hold));
    end
    check("stall_rd_en", 32'(rd_en[0]), 32'(0));
    check("stall_credit", 32'(occ_m[0] + infl_m(0)), 32'(3));
    ready[0] = 1'b1;
    for (k = 0; k < 40 && beats[0] < 10; k++) tick();
    check("stream_beats", 32'(beats[0]), 32'(10));
    repeat (3) tick();
    check("stream_leftover", 32'(qsize(0)), 32'(0));

    // Line boundary: 9 beats with 4-pixel lines
    rst = 1'b1; tick(); rst = 1'b0;
    b0 = beats[0]; e0 = eol_cnt[0]; l0 = ld_cnt[0];
    avail[0] = 9; apply();
    for (k = 0; k < 40 && beats[0] - b0 < 9; k++) tick();
    tick(); tick();
    check("line_beats", 32'(beats[0] - b0), 32'(9));
    check("line_eol_count", 32'(eol_cnt[0] - e0), 32'(2));
    check("line_done_count", 32'(ld_cnt[0] - l0), 32'(2));
    #2;
    check("line_pix_after", 32'(pix[0]), 32'(1));

    // Drain: enable falls with occ=2, infl=1
    ready[0] = 1'b0; avail[0] = 20; apply();
    for (k = 0; k < 20 && !(occ_m[0] == 2 && infl_m(0) == 1); k++) tick();
    check("drain_setup", 32'(occ_m[0] == 2 && infl_m(0) == 1), 32'(1));
    en[0] = 1'b0; ready[0] = 1'b1;
    b0 = beats[0]; rc = rd_cnt[0];
    repeat (10) tick();
    check("drain_beats", 32'(beats[0] - b0), 32'(3));
    check("drain_no_reads", 32'(rd_cnt[0] - rc), 32'(0));
    #2;
    check("drain_rd_en", 32'(rd_en[0]), 32'(0));

    // FIFO permanently empty
    force_empty[0] = 1'b1; en[0] = 1'b1; apply();
    rc = rd_cnt[0];
    repeat (20) tick();
    check("empty_no_reads", 32'(rd_cnt[0] - rc), 32'(0));
    #2;
    check("empty_valid", 32'(valid[0]), 32'(0));
    force_empty[0] = 1'b0; apply();

    // Reset mid-flight with occ=2, infl=1
    b0 = beats[0];
    for (k = 0; k < 30 && beats[0] - b0 < 5; k++) tick();
    ready[0] = 1'b0;
    for (k = 0; k < 20 && !(occ_m[0] == 2 && infl_m(0) == 1); k++) tick();
    check("reset_setup", 32'(occ_m[0] == 2 && infl_m(0) == 1), 32'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    en[0] = 1'b0; ready[0] = 1'b1;
    #2;
    check("reset_valid", 32'(valid[0]), 32'(0));
    check("reset_pix", 32'(pix[0]), 32'(0));
    b0 = beats[0];
    repeat (6) tick();
    check("reset_late_return", 32'(beats[0] - b0), 32'(0));

    // Random backpressure and empty on both latencies
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; rnd_mode[i] = 1'b1; b0 = beats[i];
    end
    repeat (10000) tick();
    for (int i = 0; i < 2; i++) begin
      rnd_mode[i] = 1'b0; en[i] = 1'b0; ready[i] = 1'b1; force_empty[i] = 1'b0;
    end
    apply();
    repeat (12) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rand_leftover%0d", i), 32'(qsize(i)), 32'(0));
      check($sformatf("rand_progress%0d", i), 32'(beats[i] > 2000), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_line_rd_stream.md
FIFO_LINE_RD_STREAM -- requirements
Module: fifo_line_rd_stream

Interface
REQ-001 The block SHALL take parameter c_DATA_WIDTH, default 1, which sets the pixel data width.
REQ-002 The block SHALL take parameter c_RD_LATENCY, default 1, which sets the FIFO read latency from rd_en to valid data; only 1 (no output reg) and 2 (output reg) are legal.
REQ-003 The block SHALL take parameter c_LINE_LEN, default 1920, which sets the pixels per line; legal range 2..4095.
REQ-004 The block SHALL take parameter c_CNT_WIDTH, default 12, which sets the width of the pixel counter.
REQ-005 The block SHALL have the following ports (clock and reset first):
- rd_clk  in  1  sole clock.
- rd_rst  in  1  synchronous, active-high reset.
- enable  in  1  permits new FIFO reads.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  c_DATA_WIDTH  FIFO read data.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  c_DATA_WIDTH  output pixel.
- m_eol  out  1  the current beat is the last pixel of a line.
- line_done  out  1  one-cycle pulse per completed line.
- pix_cnt  out  c_CNT_WIDTH  index of the current output pixel within its line.
REQ-006 The block SHALL use one clock only (rd_clk); reset SHALL be synchronous and active-high (rd_rst).

Function
REQ-007 The block SHALL hold an internal buffer of DEPTH = c_RD_LATENCY+1 entries (FIFO order), plus an in-flight counter `infl` that tracks issued reads not yet returned.
REQ-008 fifo_rd_en SHALL be combinational and asserted when all of the following hold:
- enable=1
- fifo_rd_empty=0
- state=RUN
- occ + infl < DEPTH, where occ is the buffer occupancy after any pop in the same cycle is counted.
REQ-009 Data returns exactly c_RD_LATENCY cycles after fifo_rd_en and SHALL be captured into the buffer that cycle, unconditionally.
REQ-010 m_valid SHALL equal (occ != 0).
REQ-011 m_data SHALL present the head entry.
REQ-012 A beat transfers when m_valid & m_ready, and the head pops that cycle.
REQ-013 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-014 Throughput SHALL be 1 beat/cycle sustained when the FIFO is non-empty and m_ready=1 continuously.
REQ-015 A simultaneous push and pop SHALL leave occ unchanged.
REQ-016 The buffer SHALL never overflow, guaranteed by the REQ-008 credit rule; an overflow is an assertion failure.
REQ-017 pix_cnt SHALL increment on each transfer and wrap from c_LINE_LEN-1 to 0.
REQ-018 m_eol SHALL equal m_valid & (pix_cnt == c_LINE_LEN-1).
REQ-019 line_done SHALL pulse high for one cycle, the cycle after a transfer with m_eol=1.
REQ-020 The state machine SHALL have three states, with these transitions:
- RUN -> DRAIN when enable falls: no new reads are issued; in-flight data still lands; output continues.
- DRAIN -> IDLE when infl=0 and occ=0.
- IDLE -> RUN when enable=1.
- DRAIN -> RUN directly when enable returns to 1.
REQ-021 pix_cnt SHALL NOT reset on enable changes; lines resume where they stopped.
REQ-022 fifo_rd_empty rising while reads are in flight SHALL have no effect on data already issued.
REQ-023 m_ready is don't-care when m_valid=0.

Reset
REQ-024 While rd_rst=1, the block SHALL drive or set the following:
- fifo_rd_en=0
- m_valid=0
- m_eol=0
- line_done=0
- pix_cnt=0
- m_data=0
- occ=0
- infl=0
- state=IDLE
REQ-025 Reset asserted mid-operation SHALL discard buffered and in-flight data; FIFO returns arriving after reset SHALL be ignored for c_RD_LATENCY cycles.
REQ-026 The first fifo_rd_en after reset SHALL occur no earlier than the cycle after rd_rst deasserts.

Verification
REQ-027 The bench SHALL cover stream with stall: c_RD_LATENCY=2, FIFO holds 10 words, m_ready=1 -> m_data follows FIFO order at 1 beat/cycle; then m_ready=0 for 5 cycles -> m_valid held, fifo_rd_en=0 after occ+infl=3, no loss or duplication.
REQ-028 The bench SHALL cover line boundary: c_LINE_LEN=4, 9 beats -> m_eol on beats 3 and 7, line_done pulses twice, pix_cnt=1 after the run.
REQ-029 The bench SHALL cover drain: enable falls with infl=1, occ=2 -> 3 more beats emitted, then state IDLE, fifo_rd_en stays 0.
REQ-030 The bench SHALL cover FIFO empty: fifo_rd_empty=1 throughout -> fifo_rd_en=0 and m_valid=0 forever.
REQ-031 The bench SHALL cover reset: rd_rst pulsed with occ=2, infl=1 -> next cycle m_valid=0 and pix_cnt=0; the late FIFO return is not emitted.
REQ-032 The bench SHALL cover random backpressure: 10k cycles, random m_ready and random empty, both latencies -> scoreboard exact match and the no-overflow assertion never fires.
